dual_port_ram: RTL and testbench
================================

# dual_port_ram

- Parametrised successor to the team's single-port `single_ram`.
- Has one dedicated write port (A) with per-lane byte enables and one dedicated read port (B) with registered, valid-qualified read data.
- A built-in clear engine zeroes the whole array after reset or on request.
- Sits between the datapath and its local buffer storage, replacing the shared tri-state data bus with separate unidirectional buses.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: address bits; depth DEPTH = 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width; must be a multiple of LANE_WIDTH.
- `LANE_WIDTH`, 8: byte-enable granularity; LANES = DATA_WIDTH/LANE_WIDTH.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_cs`  in  1  write-port select.
- `a_we`  in  1  write enable; a write occurs only when a_cs=1 and a_we=1.
- `a_be`  in  LANES  per-lane write enable; bit i covers data bits [i*LANE_WIDTH +: LANE_WIDTH].
- `a_addr`  in  ADDR_WIDTH  write address.
- `a_wdata`  in  DATA_WIDTH  write data.
- `b_cs`  in  1  read request.
- `b_addr`  in  ADDR_WIDTH  read address.
- `b_rdata`  out  DATA_WIDTH  registered read data.
- `b_rvalid`  out  1  one-cycle pulse; b_rdata holds a new read result.
- `clear_req`  in  1  starts a full-array clear when sampled high in READY.
- `busy`  out  1  clear engine active; all port accesses are dropped.
- `dropped`  out  1  sticky flag; an access arrived while busy.

## Operation

FSM states: CLEAR and READY.
- `rst`=1: state <= CLEAR, clear pointer <= 0, b_rdata <= 0, b_rvalid <= 0, dropped <= 0, busy = 1.
- CLEAR, each cycle with rst=0: write all-zero word to mem[ptr] and increment ptr. When ptr = DEPTH-1 is written, go to READY on the next edge.
- READY: clear_req=1 sets ptr <= 0 and state <= CLEAR. A clear_req asserted during CLEAR is ignored and not queued.
- `busy` = (state == CLEAR), decoded combinationally from the state register.

Write (READY only):
- For each lane i with a_cs & a_we & a_be[i], mem[a_addr] lane i <= a_wdata lane i.
- Unselected lanes keep their contents. a_be = 0 is a no-op.

Read (READY only):
- b_cs=1 at edge n gives b_rdata = mem[b_addr] and b_rvalid=1 after edge n.
- Without b_cs, b_rvalid=0 and b_rdata holds its previous value.

Collision rule (write-first):
- When a write and a read hit the same address in the same cycle, b_rdata returns the merged word per lane.
- Enabled lanes return the new a_wdata; disabled lanes return the old contents.

Access while busy:
- Any a_cs or b_cs while busy is dropped: no array change and b_rvalid stays 0.
- `dropped` is set to 1 and stays 1 until rst.
- An access in the same cycle as the clear_req that starts a clear is still serviced, because state is READY in that cycle.

Addresses cover the full 2**ADDR_WIDTH range, so there is no out-of-range case. The clear pointer is ADDR_WIDTH bits and its terminal count is all-ones.

## Timing

- Reset values: b_rdata=0, b_rvalid=0, dropped=0, busy=1.
- After rst falls, busy stays high for exactly DEPTH cycles (1024 with defaults), then goes low.
- Read latency: 1 cycle, address to b_rdata/b_rvalid. Read throughput is one per cycle.
- Write latency: 1 cycle. A read issued the cycle after a write sees the new data.
- clear_req sampled at edge n: busy=1 from n+1 for DEPTH cycles.
- rst asserted mid-clear: ptr returns to 0 and the full DEPTH-cycle clear restarts after rst falls.
- rst asserted during a pending read: b_rvalid=0 on the next edge.

## Test plan

1. Reset release, then poll: busy=1 for 1024 cycles, then 0. Reading every address 0..1023 returns 0x00000000 with b_rvalid one cycle after each b_cs.
2. Write addresses 0..15 with random data and a_be=4'hF, then read them back: each b_rdata equals the written word with 1-cycle latency. Back-to-back reads give b_rvalid high for 16 consecutive cycles.
3. Write 0xAABBCCDD to address 5, then write 0x11223344 with a_be=4'b0101: reading address 5 returns 0xAA22CC44.
4. Collision: mem[7]=0x0, then the same cycle writes 0xDEADBEEF with a_be=4'b1100 and reads address 7: b_rdata=0xDEAD0000. A read the next cycle returns the same value.
5. After data is loaded, pulse clear_req: busy high for 1024 cycles. A write and a read issued mid-clear set dropped=1 and produce no b_rvalid. After the clear, all addresses read 0.
6. Assert rst at clear pointer ≈ 500, holding 2 cycles: busy stays high for a full 1024 cycles after release, and dropped=0.

Source files
------------

// File: rtl/dual_port_ram.sv
// Dual-port RAM: one byte-enabled write port (A), one registered read port (B),
// and a clear engine that zeroes the whole array after reset or on request.
module dual_port_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             a_cs,
  input  logic                             a_we,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_wdata,
  input  logic                             b_cs,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  output logic [DATA_WIDTH-1:0]            b_rdata,
  output logic                             b_rvalid,
  input  logic                             clear_req,
  output logic                             busy,
  output logic                             dropped
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    dropped_q, dropped_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [LANES-1:0]        mem_be_s;
  logic [ADDR_WIDTH-1:0]   mem_waddr_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_s;
  logic                    wr_en_s;
  logic [DATA_WIDTH-1:0]   old_word_s;
  logic [DATA_WIDTH-1:0]   merged_word_s;

  // Expand per-lane enables into a bit mask over the data word.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [LANES-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    m = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      m[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{be[i]}};
    end
    return m;
  endfunction

  assign wr_en_s    = a_cs & a_we;
  assign old_word_s = mem_q[b_addr];

  // Write-first bypass: lanes being written this cycle return the new data.
  always_comb begin
    if (wr_en_s && (a_addr == b_addr)) begin
      merged_word_s = (a_wdata & lane_mask(a_be)) | (old_word_s & ~lane_mask(a_be));
    end else begin
      merged_word_s = old_word_s;
    end
  end

  // Next-state, array write selection and read-port update.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    dropped_d   = dropped_q;
    mem_be_s    = {LANES{1'b0}};
    mem_waddr_s = a_addr;
    mem_wdata_s = a_wdata;

    case (state_q)
      S_CLEAR: begin
        mem_be_s    = {LANES{1'b1}};
        mem_waddr_s = ptr_q;
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        ptr_d       = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = S_READY;
        end else begin
          state_d = S_CLEAR;
        end
        // clear_req is deliberately ignored here; it is not queued.
        if (a_cs || b_cs) begin
          dropped_d = 1'b1;
        end else begin
          dropped_d = dropped_q;
        end
      end

      S_READY: begin
        if (wr_en_s) begin
          mem_be_s = a_be;
        end else begin
          mem_be_s = {LANES{1'b0}};
        end
        if (b_cs) begin
          rdata_d  = merged_word_s;
          rvalid_d = 1'b1;
        end else begin
          rdata_d  = rdata_q;
          rvalid_d = 1'b0;
        end
        if (clear_req) begin
          state_d = S_CLEAR;
          ptr_d   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_d = S_READY;
          ptr_d   = ptr_q;
        end
      end

      default: begin
        state_d = S_CLEAR;
        ptr_d   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Control and read-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      ptr_q     <= {ADDR_WIDTH{1'b0}};
      rdata_q   <= {DATA_WIDTH{1'b0}};
      rvalid_q  <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      dropped_q <= dropped_d;
    end
  end

  // Storage array; no writes of any kind land while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_be_s[i]) begin
          mem_q[mem_waddr_s][i*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata_s[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  assign busy     = (state_q == S_CLEAR);
  assign b_rdata  = rdata_q;
  assign b_rvalid = rvalid_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram with default parameters.
module tb_dual_port_ram;

  logic        clk;
  logic        rst;
  logic        a_cs;
  logic        a_we;
  logic [3:0]  a_be;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_cs;
  logic [9:0]  b_addr;
  logic [31:0] b_rdata;
  logic        b_rvalid;
  logic        clear_req;
  logic        busy;
  logic        dropped;

  int errors = 0;
  int checks = 0;

  logic [31:0] data_arr [16];
  int          cnt;
  logic        saw_rvalid;

  dual_port_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LANE_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_cs(b_cs), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .clear_req(clear_req), .busy(busy), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be);
    a_cs = 1'b1; a_we = 1'b1; a_be = be; a_addr = addr; a_wdata = data;
    @(negedge clk);
    a_cs = 1'b0; a_we = 1'b0; a_be = 4'h0;
  endtask

  task automatic rd(input string tag, input logic [9:0] addr, input logic [31:0] exp);
    b_cs = 1'b1; b_addr = addr;
    @(negedge clk);
    b_cs = 1'b0;
    check({tag, "_rvalid"}, {31'd0, b_rvalid}, 32'd1);
    check({tag, "_rdata"}, b_rdata, exp);
  endtask

  // Count edges from now until busy drops (bounded).
  task automatic wait_busy_low(output int n);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
  endtask

  initial begin
    rst = 1'b1; a_cs = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 10'd0; a_wdata = 32'd0;
    b_cs = 1'b0; b_addr = 10'd0; clear_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdata", b_rdata, 32'd0);
    check("rst_rvalid", {31'd0, b_rvalid}, 32'd0);
    check("rst_dropped", {31'd0, dropped}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    // 1: initial clear lasts 1024 cycles, then every word reads zero
    rst = 1'b0;
    wait_busy_low(cnt);
    check("t1_busy_cycles", cnt, 32'd1024);
    b_cs = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      b_addr = 10'(i);
      @(negedge clk);
      check("t1_rvalid", {31'd0, b_rvalid}, 32'd1);
      check("t1_rdata", b_rdata, 32'd0);
    end
    b_cs = 1'b0;

    // 2: full-word writes then 16 back-to-back reads
    for (int i = 0; i < 16; i++) data_arr[i] = $urandom;
    for (int i = 0; i < 16; i++) wr(10'(i), data_arr[i], 4'hF);
    b_cs = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_addr = 10'(i);
      @(negedge clk);
      check("t2_rvalid", {31'd0, b_rvalid}, 32'd1);
      check("t2_rdata", b_rdata, data_arr[i]);
    end
    b_cs = 1'b0;
    @(negedge clk);
    check("t2_idle_rvalid", {31'd0, b_rvalid}, 32'd0);
    check("t2_idle_hold", b_rdata, data_arr[15]);

    // 3: partial lane write, read the cycle right after
    wr(10'd5, 32'hAABBCCDD, 4'hF);
    wr(10'd5, 32'h11223344, 4'b0101);
    rd("t3_merge", 10'd5, 32'hAA22CC44);
    wr(10'd8, 32'hFFFFFFFF, 4'h0);
    rd("t3_be0_noop", 10'd8, data_arr[8]);
    a_cs = 1'b1; a_we = 1'b0; a_be = 4'hF; a_addr = 10'd9; a_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    a_cs = 1'b0; a_be = 4'h0;
    rd("t3_we0_noop", 10'd9, data_arr[9]);

    // 4: same-cycle write/read collision returns merged word
    wr(10'd7, 32'h00000000, 4'hF);
    a_cs = 1'b1; a_we = 1'b1; a_be = 4'b1100; a_addr = 10'd7; a_wdata = 32'hDEADBEEF;
    rd("t4_collide", 10'd7, 32'hDEAD0000);
    a_cs = 1'b0; a_we = 1'b0; a_be = 4'h0;
    rd("t4_after", 10'd7, 32'hDEAD0000);

    // 5: clear request; read in the same cycle is serviced, mid-clear accesses dropped
    clear_req = 1'b1; b_cs = 1'b1; b_addr = 10'd5;
    @(negedge clk);
    clear_req = 1'b0; b_cs = 1'b0;
    check("t5_same_cycle_rvalid", {31'd0, b_rvalid}, 32'd1);
    check("t5_same_cycle_rdata", b_rdata, 32'hAA22CC44);
    check("t5_busy_start", {31'd0, busy}, 32'd1);
    check("t5_dropped_pre", {31'd0, dropped}, 32'd0);
    cnt = 1;
    saw_rvalid = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (cnt == 500) begin
        a_cs = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 10'd3; a_wdata = 32'hFFFFFFFF;
        b_cs = 1'b1; b_addr = 10'd3;
      end
      @(negedge clk);
      a_cs = 1'b0; a_we = 1'b0; a_be = 4'h0; b_cs = 1'b0;
      if (b_rvalid) saw_rvalid = 1'b1;
      if (!busy) break;
      cnt++;
    end
    check("t5_busy_cycles", cnt, 32'd1024);
    check("t5_no_rvalid", {31'd0, saw_rvalid}, 32'd0);
    check("t5_dropped", {31'd0, dropped}, 32'd1);
    rd("t5_zero_a3", 10'd3, 32'd0);
    rd("t5_zero_a5", 10'd5, 32'd0);
    rd("t5_zero_a7", 10'd7, 32'd0);
    rd("t5_zero_a1023", 10'd1023, 32'd0);
    check("t5_dropped_sticky", {31'd0, dropped}, 32'd1);

    // 6a: reset while a read is pending
    wr(10'd9, 32'h12345678, 4'hF);
    rd("t6_prime", 10'd9, 32'h12345678);
    b_cs = 1'b1; b_addr = 10'd9; rst = 1'b1;
    @(negedge clk);
    b_cs = 1'b0;
    check("t6_rst_rvalid", {31'd0, b_rvalid}, 32'd0);
    check("t6_rst_rdata", b_rdata, 32'd0);
    check("t6_rst_dropped", {31'd0, dropped}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_busy_low(cnt);
    check("t6_busy_cycles_a", cnt, 32'd1024);

    // 6b: reset in the middle of a requested clear restarts the full clear
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int k = 0; k < 499; k++) @(negedge clk);
    check("t6_midclear_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_busy_low(cnt);
    check("t6_busy_cycles_b", cnt, 32'd1024);
    check("t6_dropped", {31'd0, dropped}, 32'd0);
    rd("t6_zero_a9", 10'd9, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
